// File: rtl/snoopy_invalidate_pkg.sv
// Shared types for the snoop-side invalidate-protocol controller.
package snoopy_invalidate_pkg;

  typedef enum logic [1:0] {
    LINE_INVALID  = 2'b00,
    LINE_SHARED   = 2'b01,
    LINE_MODIFIED = 2'b10
  } line_state_e;

  typedef enum logic [1:0] {
    CMD_NONE               = 2'b00,
    CMD_BUS_READ           = 2'b01,
    CMD_BUS_READ_EXCLUSIVE = 2'b10,
    CMD_BUS_INVALIDATE     = 2'b11
  } bus_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_FLUSH,
    ST_UPDATE,
    ST_RESPOND
  } fsm_state_e;

endpackage

// File: rtl/snoopy_invalidate_controller_flush_counter.sv
// Word-offset counter walking a block during a flush; wraps naturally.
module snoopy_flush_counter #(
  parameter int unsigned OFFSET_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    clear,
  output logic [OFFSET_WIDTH-1:0] count,
  output logic                    last
);

  // Advance on each accepted beat, park at zero outside a flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + OFFSET_WIDTH'(1);
    end
  end

  assign last = &count;

endmodule

// File: rtl/snoopy_invalidate_controller.sv
// Snoop-side controller: looks up snooped lines, flushes dirty data,
// downgrades/invalidates the line state and acknowledges the bus.
module snoopy_invalidate_controller
  import snoopy_invalidate_pkg::*;
#(
  parameter int unsigned TAG_WIDTH    = 6,
  parameter int unsigned INDEX_WIDTH  = 6,
  parameter int unsigned OFFSET_WIDTH = 4,
  parameter int unsigned DATA_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    busRequest,
  input  logic [1:0]              busCommand,
  input  logic [TAG_WIDTH-1:0]    busTag,
  input  logic [INDEX_WIDTH-1:0]  busIndex,
  output logic                    busAck,
  output logic                    busShared,
  output logic [DATA_WIDTH-1:0]   busDataOut,
  output logic [OFFSET_WIDTH-1:0] busDataOffset,
  output logic                    busDataValid,
  input  logic                    busDataReady,
  output logic [INDEX_WIDTH-1:0]  snoopyIndex,
  output logic [OFFSET_WIDTH-1:0] snoopyOffset,
  output logic [TAG_WIDTH-1:0]    snoopyTagIn,
  output logic [1:0]              snoopyStateIn,
  output logic                    snoopyWriteState,
  input  logic                    snoopyHit,
  input  logic [1:0]              snoopyStateOut,
  input  logic [DATA_WIDTH-1:0]   snoopyDataOut
);

  fsm_state_e  state_q, state_next;
  bus_cmd_e    cmd_q;
  line_state_e new_state_q, new_state_next;
  logic        present_q, present_next;
  logic        latch;
  logic [TAG_WIDTH-1:0]    tag_q;
  logic [INDEX_WIDTH-1:0]  index_q;
  logic [OFFSET_WIDTH-1:0] count;
  logic        last;

  logic        ack_next, shared_next, write_next, valid_next;
  line_state_e state_in_next;
  line_state_e state_in_q;

  snoopy_flush_counter #(.OFFSET_WIDTH(OFFSET_WIDTH)) u_counter (
    .clock  (clock),
    .reset  (reset),
    .enable (busDataReady && (state_q == ST_FLUSH)),
    .clear  (state_q != ST_FLUSH),
    .count  (count),
    .last   (last)
  );

  // State and decision registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      new_state_q <= LINE_INVALID;
      present_q   <= 1'b0;
    end else begin
      state_q     <= state_next;
      new_state_q <= new_state_next;
      present_q   <= present_next;
    end
  end

  // Capture the snooped transaction when it is accepted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cmd_q   <= CMD_NONE;
      tag_q   <= '0;
      index_q <= '0;
    end else if (latch) begin
      cmd_q   <= bus_cmd_e'(busCommand);
      tag_q   <= busTag;
      index_q <= busIndex;
    end
  end

  // Next-state logic and next values of the registered outputs.
  always_comb begin
    state_next     = state_q;
    new_state_next = new_state_q;
    present_next   = present_q;
    latch          = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (busRequest && (busCommand != 2'(CMD_NONE))) begin
          latch      = 1'b1;
          state_next = ST_CHECK;
        end
      end
      ST_CHECK: begin
        present_next   = 1'b0;
        new_state_next = LINE_INVALID;
        state_next     = ST_RESPOND;
        if (snoopyHit) begin
          case (snoopyStateOut)
            2'(LINE_SHARED): begin
              present_next = 1'b1;
              if (cmd_q != CMD_BUS_READ) state_next = ST_UPDATE;
            end
            2'(LINE_MODIFIED): begin
              // Invalidate against a dirty line is treated as read-exclusive.
              present_next   = 1'b1;
              new_state_next = (cmd_q == CMD_BUS_READ) ? LINE_SHARED : LINE_INVALID;
              state_next     = ST_FLUSH;
            end
            default: ;
          endcase
        end
      end
      ST_FLUSH: begin
        if (busDataReady && last) state_next = ST_UPDATE;
      end
      ST_UPDATE:  state_next = ST_RESPOND;
      ST_RESPOND: state_next = ST_IDLE;
      default:    state_next = ST_IDLE;
    endcase

    ack_next      = (state_next == ST_RESPOND);
    shared_next   = (state_next == ST_RESPOND) && present_next;
    write_next    = (state_next == ST_UPDATE);
    valid_next    = (state_next == ST_FLUSH);
    state_in_next = (state_next == ST_UPDATE) ? new_state_next : LINE_INVALID;
  end

  // Output registers, aligned with the state they belong to.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      busAck           <= 1'b0;
      busShared        <= 1'b0;
      snoopyWriteState <= 1'b0;
      busDataValid     <= 1'b0;
      state_in_q       <= LINE_INVALID;
    end else begin
      busAck           <= ack_next;
      busShared        <= shared_next;
      snoopyWriteState <= write_next;
      busDataValid     <= valid_next;
      state_in_q       <= state_in_next;
    end
  end

  assign snoopyStateIn = state_in_q;
  assign snoopyTagIn   = tag_q;
  assign snoopyIndex   = index_q;
  assign snoopyOffset  = count;
  // Flush data comes straight from the cache read port for the current offset.
  assign busDataOut    = busDataValid ? snoopyDataOut : '0;
  assign busDataOffset = busDataValid ? count : '0;

endmodule

// File: tb/tb_snoopy_invalidate_controller.sv
// Bench for the snoop controller with a one-line cache model.
module tb_snoopy_invalidate_controller;

  localparam logic [5:0] LINE_TAG = 6'h05;
  localparam logic [5:0] LINE_IDX = 6'h03;

  logic        clock = 1'b0;
  logic        reset;
  logic        busRequest;
  logic [1:0]  busCommand;
  logic [5:0]  busTag;
  logic [5:0]  busIndex;
  logic        busAck;
  logic        busShared;
  logic [15:0] busDataOut;
  logic [3:0]  busDataOffset;
  logic        busDataValid;
  logic        busDataReady;
  logic [5:0]  snoopyIndex;
  logic [3:0]  snoopyOffset;
  logic [5:0]  snoopyTagIn;
  logic [1:0]  snoopyStateIn;
  logic        snoopyWriteState;
  logic        snoopyHit;
  logic [1:0]  snoopyStateOut;
  logic [15:0] snoopyDataOut;

  logic [1:0]  line_state;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0]  off;
    logic [15:0] data;
  } beat_t;
  beat_t sb[$];

  typedef struct {
    logic [1:0] cmd;
    logic [5:0] tag;
    logic [5:0] idx;
    logic [1:0] line_st;
    int         stall_off;
    int         stall_len;
    int         exp_ack;
    logic       exp_shared;
    int         exp_writes;
    logic [1:0] exp_final;
    int         exp_beats;
  } vec_t;
  vec_t vecs[10];

  snoopy_invalidate_controller dut (
    .clock            (clock),
    .reset            (reset),
    .busRequest       (busRequest),
    .busCommand       (busCommand),
    .busTag           (busTag),
    .busIndex         (busIndex),
    .busAck           (busAck),
    .busShared        (busShared),
    .busDataOut       (busDataOut),
    .busDataOffset    (busDataOffset),
    .busDataValid     (busDataValid),
    .busDataReady     (busDataReady),
    .snoopyIndex      (snoopyIndex),
    .snoopyOffset     (snoopyOffset),
    .snoopyTagIn      (snoopyTagIn),
    .snoopyStateIn    (snoopyStateIn),
    .snoopyWriteState (snoopyWriteState),
    .snoopyHit        (snoopyHit),
    .snoopyStateOut   (snoopyStateOut),
    .snoopyDataOut    (snoopyDataOut)
  );

  always #5 clock = ~clock;

  // One-line cache: word k holds k*0x1111.
  assign snoopyHit      = (snoopyTagIn == LINE_TAG) && (snoopyIndex == LINE_IDX);
  assign snoopyStateOut = line_state;
  assign snoopyDataOut  = 16'(snoopyOffset) * 16'h1111;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] cmd, input logic [5:0] tag, input logic [5:0] idx,
                              input logic [1:0] st, input int soff, input int slen, input int ack,
                              input logic sh, input int wr, input logic [1:0] fin, input int beats);
    vec_t v;
    v.cmd = cmd; v.tag = tag; v.idx = idx; v.line_st = st;
    v.stall_off = soff; v.stall_len = slen; v.exp_ack = ack; v.exp_shared = sh;
    v.exp_writes = wr; v.exp_final = fin; v.exp_beats = beats;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int id);
    int   cyc = 0;
    int   writes = 0;
    int   write_cyc = -1;
    int   valid_cycles = 0;
    int   stalls = 0;
    logic got_ack = 1'b0;
    beat_t b;
    line_state = v.line_st;
    sb.delete();
    for (int k = 0; k < v.exp_beats; k++) begin
      b.off  = 4'(k);
      b.data = 16'(k * 32'h1111);
      sb.push_back(b);
    end
    @(negedge clock);
    busRequest = 1'b1; busCommand = v.cmd; busTag = v.tag; busIndex = v.idx; busDataReady = 1'b1;
    while (!got_ack && cyc < 60) begin
      @(negedge clock);
      cyc++;
      if (busDataValid) begin
        valid_cycles++;
        if (int'(busDataOffset) == v.stall_off && stalls < v.stall_len) begin
          busDataReady = 1'b0;
          stalls++;
        end else begin
          busDataReady = 1'b1;
          if (sb.size() == 0) begin
            check($sformatf("v%0d_extra_beat", id), 32'(busDataOffset), 32'hFFFF_FFFF);
          end else begin
            b = sb.pop_front();
            check($sformatf("v%0d_beat_off", id), 32'(busDataOffset), 32'(b.off));
            check($sformatf("v%0d_beat_data", id), 32'(busDataOut), 32'(b.data));
          end
        end
      end else begin
        busDataReady = 1'b1;
      end
      if (snoopyWriteState) begin
        writes++;
        write_cyc = cyc;
        line_state = snoopyStateIn;
      end
      if (busAck) begin
        got_ack = 1'b1;
        check($sformatf("v%0d_ack_cycle", id), 32'(cyc), 32'(v.exp_ack));
        check($sformatf("v%0d_shared", id), 32'(busShared), 32'(v.exp_shared));
        busRequest = 1'b0;
        busCommand = 2'b00;
      end
    end
    if (!got_ack) check($sformatf("v%0d_ack_timeout", id), 32'd0, 32'd1);
    check($sformatf("v%0d_writes", id), 32'(writes), 32'(v.exp_writes));
    if (writes == 1) check($sformatf("v%0d_write_cycle", id), 32'(write_cyc), 32'(v.exp_ack - 1));
    check($sformatf("v%0d_final_state", id), 32'(line_state), 32'(v.exp_final));
    check($sformatf("v%0d_valid_cycles", id), 32'(valid_cycles), 32'(v.exp_beats + v.stall_len));
    check($sformatf("v%0d_beats_left", id), 32'(sb.size()), 32'd0);
    @(negedge clock);
    check($sformatf("v%0d_ack_pulse", id), 32'(busAck), 32'd0);
  endtask

  initial begin
    reset = 1'b0; busRequest = 1'b0; busCommand = 2'b00; busTag = '0; busIndex = '0;
    busDataReady = 1'b1; line_state = 2'b00;

    //            cmd    tag    idx    line   soff slen ack sh wr fin  beats
    vecs[0] = mk(2'b01, 6'h06, 6'h03, 2'b01, -1, 0,  2,  0, 0, 2'b01, 0);
    vecs[1] = mk(2'b01, 6'h05, 6'h03, 2'b00, -1, 0,  2,  0, 0, 2'b00, 0);
    vecs[2] = mk(2'b01, 6'h05, 6'h03, 2'b01, -1, 0,  2,  1, 0, 2'b01, 0);
    vecs[3] = mk(2'b10, 6'h05, 6'h03, 2'b01, -1, 0,  3,  1, 1, 2'b00, 0);
    vecs[4] = mk(2'b11, 6'h05, 6'h03, 2'b01, -1, 0,  3,  1, 1, 2'b00, 0);
    vecs[5] = mk(2'b01, 6'h05, 6'h03, 2'b10, -1, 0,  19, 1, 1, 2'b01, 16);
    vecs[6] = mk(2'b01, 6'h05, 6'h03, 2'b10,  7, 3,  22, 1, 1, 2'b01, 16);
    vecs[7] = mk(2'b10, 6'h05, 6'h03, 2'b10, -1, 0,  19, 1, 1, 2'b00, 16);
    vecs[8] = mk(2'b11, 6'h05, 6'h03, 2'b10, -1, 0,  19, 1, 1, 2'b00, 16);
    vecs[9] = mk(2'b01, 6'h05, 6'h04, 2'b10, -1, 0,  2,  0, 0, 2'b10, 0);

    repeat (2) @(negedge clock);
    check("reset_outputs",
          {busAck, busShared, busDataOut, busDataOffset, busDataValid, snoopyIndex,
           snoopyOffset, snoopyTagIn, snoopyStateIn, snoopyWriteState} == '0, 32'd1);
    reset = 1'b1;
    @(negedge clock);

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // NONE command with request held must be ignored.
    begin
      int activity = 0;
      busRequest = 1'b1; busCommand = 2'b00; busTag = LINE_TAG; busIndex = LINE_IDX;
      repeat (5) begin
        @(negedge clock);
        if (busAck || busDataValid || snoopyWriteState) activity++;
      end
      busRequest = 1'b0;
      check("none_ignored", 32'(activity), 32'd0);
    end

    // Reset in the middle of a flush at offset 5.
    begin
      int   cyc = 0;
      int   writes = 0;
      logic hit5 = 1'b0;
      line_state = 2'b10;
      @(negedge clock);
      busRequest = 1'b1; busCommand = 2'b01; busTag = LINE_TAG; busIndex = LINE_IDX; busDataReady = 1'b1;
      while (!hit5 && cyc < 40) begin
        @(negedge clock);
        cyc++;
        if (snoopyWriteState) writes++;
        if (busDataValid && busDataOffset == 4'd5) hit5 = 1'b1;
      end
      check("rst_reach_offset5", 32'(hit5), 32'd1);
      reset = 1'b0;
      #1;
      check("rst_mid_outputs",
            {busAck, busShared, busDataOut, busDataOffset, busDataValid, snoopyIndex,
             snoopyOffset, snoopyTagIn, snoopyStateIn, snoopyWriteState} == '0, 32'd1);
      busRequest = 1'b0; busCommand = 2'b00;
      @(negedge clock);
      if (snoopyWriteState) writes++;
      check("rst_no_write", 32'(writes), 32'd0);
      check("rst_line_kept", 32'(line_state), 32'h2);
      reset = 1'b1;
      run_vec(vecs[0], 10);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
